// File: rtl/link_pkg.sv
// Shared types and defaults for the off-chip link transmit path.
package link_pkg;

  localparam int unsigned LINK_DATA_W  = 64;
  localparam int unsigned LINK_CREDITS = 8;
  localparam int unsigned LINK_CW      = 4;

  typedef logic [LINK_DATA_W-1:0] link_word_t;
  typedef logic [LINK_CW-1:0]     credit_t;

  // Output holding register occupancy.
  typedef enum logic {StEmpty, StFull} out_state_e;

endpackage

// File: rtl/link_tx_scheduler_if.sv
// Requester-side and link-side signals of the transmit scheduler.
interface link_tx_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned CW      = 4,
  parameter int unsigned IDW     = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      link_valid;
  logic [DATA_W-1:0]         link_data;
  logic [IDW-1:0]            link_src;
  logic                      link_ready;
  logic                      token_in;
  logic [CW-1:0]             credits;
  logic                      credit_err;

  // Scheduler side.
  modport master (
    input  req_valid, req_data, link_ready, token_in,
    output req_ready, link_valid, link_data, link_src, credits, credit_err
  );

  // Requesters, serializer and credit return.
  modport slave (
    output req_valid, req_data, link_ready, token_in,
    input  req_ready, link_valid, link_data, link_src, credits, credit_err
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic        found;
  int unsigned idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
    if (en && found) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/link_tx_scheduler.sv
// Round-robin, credit-flow-controlled scheduler feeding one link word register
// toward the serializer.
module link_tx_scheduler
  import link_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = LINK_DATA_W,
  parameter int unsigned CREDITS = LINK_CREDITS,
  parameter int unsigned CW      = LINK_CW,
  parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  link_tx_scheduler_if.master  bus
);

  out_state_e        state_q;
  logic [DATA_W-1:0] data_q;
  logic [IDW-1:0]    src_q;
  logic [IDW-1:0]    ptr_q;
  logic [CW-1:0]     credits_q, credits_d;
  logic              err_q;
  logic              token_q;

  logic              link_valid;
  logic              drain, slot_free, arb_en, grant, ret, ovf;
  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]    win_idx, ptr_next;
  logic [DATA_W-1:0] win_data;

  assign link_valid = (state_q == StFull);
  assign drain      = link_valid && bus.link_ready;
  assign slot_free  = !link_valid || drain;
  // Gating with rst keeps req_ready low throughout reset.
  assign arb_en     = rst && enable && slot_free && (credits_q != '0);
  assign grant      = |gnt;
  assign ret        = bus.token_in ^ token_q;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDW)
  ) u_arb (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (win_idx)
  );

  assign win_data = bus.req_data[int'(win_idx)*DATA_W +: DATA_W];
  assign ptr_next = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  // Credit consumed at grant; a return in the same cycle cancels it.
  always_comb begin
    credits_d = credits_q;
    ovf       = 1'b0;
    case ({grant, ret})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01: begin
        if (credits_q == CW'(CREDITS)) ovf = 1'b1;
        else                           credits_d = credits_q + 1'b1;
      end
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StEmpty;
      data_q    <= '0;
      src_q     <= '0;
      ptr_q     <= '0;
      credits_q <= CW'(CREDITS);
      err_q     <= 1'b0;
      token_q   <= 1'b0;
    end else begin
      token_q   <= bus.token_in;
      credits_q <= credits_d;
      if (ovf) err_q <= 1'b1;
      if (grant) ptr_q <= ptr_next;
      unique case (state_q)
        StEmpty: begin
          if (grant) begin
            state_q <= StFull;
            data_q  <= win_data;
            src_q   <= win_idx;
          end
        end
        StFull: begin
          if (grant) begin
            data_q <= win_data;
            src_q  <= win_idx;
          end else if (drain) begin
            state_q <= StEmpty;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  assign bus.req_ready  = gnt;
  assign bus.link_valid = link_valid;
  assign bus.link_data  = data_q;
  assign bus.link_src   = src_q;
  assign bus.credits    = credits_q;
  assign bus.credit_err = err_q;

endmodule

// File: tb/tb_link_tx_scheduler.sv
// Randomized and scenario-driven bench for link_tx_scheduler with a cycle-level reference model.
module tb_link_tx_scheduler;

  localparam int N   = 4;
  localparam int DW  = 64;
  localparam int CRD = 8;

  logic clk = 1'b0;
  logic rst;
  logic enable;

  link_tx_scheduler_if #(.NUM_REQ(N), .DATA_W(DW), .CW(4)) bus ();

  link_tx_scheduler dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int          m_credits;
  bit          m_valid;
  logic [63:0] m_data;
  int          m_src;
  int          m_ptr;
  bit          m_err;
  bit          m_tok;
  bit          e_grant;
  int          e_win;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_credits = CRD;
    m_valid   = 0;
    m_data    = '0;
    m_src     = 0;
    m_ptr     = 0;
    m_err     = 0;
    m_tok     = 0;
  endtask

  // Evaluate grant and expected outputs against the current inputs.
  task automatic check_outputs();
    logic [N-1:0] exp_ready;
    bit slot;
    slot    = !m_valid || bus.link_ready;
    e_grant = 0;
    e_win   = 0;
    if (enable && slot && m_credits > 0) begin
      for (int k = 0; k < N; k++) begin
        if (!e_grant && bus.req_valid[(m_ptr + k) % N]) begin
          e_grant = 1;
          e_win   = (m_ptr + k) % N;
        end
      end
    end
    exp_ready = '0;
    if (e_grant) exp_ready[e_win] = 1'b1;
    check_eq("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    check_eq("link_valid", 64'(bus.link_valid), 64'(m_valid));
    if (m_valid) begin
      check_eq("link_data", bus.link_data, m_data);
      check_eq("link_src", 64'(bus.link_src), 64'(m_src));
    end
    check_eq("credits", 64'(bus.credits), 64'(m_credits));
    check_eq("credit_err", 64'(bus.credit_err), 64'(m_err));
  endtask

  task automatic model_step();
    bit ret;
    ret   = (bus.token_in != m_tok);
    m_tok = bus.token_in;
    if (e_grant) begin
      m_valid = 1;
      m_data  = bus.req_data[e_win*DW +: DW];
      m_src   = e_win;
      m_ptr   = (e_win + 1) % N;
    end else if (m_valid && bus.link_ready) begin
      m_valid = 0;
    end
    if (e_grant && !ret) m_credits--;
    else if (ret && !e_grant) begin
      if (m_credits == CRD) m_err = 1;
      else                  m_credits++;
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the next one.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check_eq("rst_link_valid", 64'(bus.link_valid), 64'd0);
    check_eq("rst_credits", 64'(bus.credits), 64'(CRD));
    check_eq("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check_eq("rst_credit_err", 64'(bus.credit_err), 64'd0);
    check_eq("rst_link_data", bus.link_data, 64'd0);
    check_eq("rst_link_src", 64'(bus.link_src), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic rand_data();
    for (int w = 0; w < N; w++) bus.req_data[w*DW +: DW] = {$urandom, $urandom};
  endtask

  initial begin
    rst            = 1'b0;
    enable         = 1'b1;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.link_ready = 1'b0;
    bus.token_in   = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Single requester drains all credits, then stalls.
    bus.req_valid  = 4'b0001;
    bus.req_data[0 +: DW] = 64'hA5;
    bus.link_ready = 1'b1;
    for (int i = 0; i < 12; i++) cycle();
    check_eq("credits_exhausted", 64'(bus.credits), 64'd0);

    // All requesting, token toggling every cycle: rotation with steady credits.
    do_reset();
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      rand_data();
      bus.token_in = ~bus.token_in;
      cycle();
    end

    // Backpressure for five cycles.
    bus.link_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      cycle();
    end
    bus.link_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Overflow return while idle.
    do_reset();
    bus.req_valid = '0;
    bus.token_in  = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    check_eq("err_sticky", 64'(bus.credit_err), 64'd1);
    bus.token_in = 1'b0;
    do_reset();

    // Zero credits with a held word, then drain plus return together.
    bus.req_valid  = 4'b0001;
    bus.link_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_data();
      cycle();
    end
    bus.link_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    bus.link_ready = 1'b1;
    bus.token_in   = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Reset mid-operation with a held word and three credits left.
    bus.token_in = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) cycle();
    check_eq("pre_rst_credits", 64'(bus.credits), 64'd3);
    #2;
    do_reset();
    bus.req_valid = 4'b0100;
    for (int i = 0; i < 3; i++) cycle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      enable         = ($urandom_range(0, 9) != 0);
      bus.req_valid  = 4'($urandom);
      bus.link_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) bus.token_in = ~bus.token_in;
      rand_data();
      if ($urandom_range(0, 99) == 0) do_reset();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/link_tx_scheduler.md
Name: link_tx_scheduler

Overview:
- Transmit-side scheduler for the off-chip link.
- Shares a single 64-bit link between NUM_REQ core requesters using round-robin arbitration.
- Enforces credit-based flow control against the receive-side channel buffers (8 entries each).
- Sits between the core requesters and the upstream serializer. Credits return through a toggling token line from the downstream side.

Parameters:
- NUM_REQ, 4, number of requesters; minimum 2.
- DATA_W, 64, link word width.
- CREDITS, 8, initial and maximum credit count; equals the downstream buffer depth.
- CW, 4, credit counter width; must hold CREDITS.
- IDW, 2, requester id width; equals clog2(NUM_REQ).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- enable  in  1  when 0, no new grants are issued; a held output word still drains.
- req_valid  in  NUM_REQ  per-requester valid.
- req_data  in  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot accept; at most one bit high per cycle.
- link_valid  out  1  output word valid toward the serializer.
- link_data  out  DATA_W  output word.
- link_src  out  IDW  index of the requester that supplied link_data.
- link_ready  in  1  serializer accepts the word when link_valid && link_ready.
- token_in  in  1  credit-return toggle; each level change returns one credit.
- credits  out  CW  current credit count.
- credit_err  out  1  sticky flag for a credit-return overflow.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - credits=CREDITS; link_valid=0; link_data=0; link_src=0; credit_err=0.
  - RR pointer=0; token_q=0.
  - req_ready=0 while in reset.
- Output stage: one holding register with states EMPTY and FULL.
- Drain condition: drain = link_valid && link_ready.
- Slot free: slot_free = !link_valid || drain.
- Grant condition: grant = enable && slot_free && credits!=0 && |req_valid.
- Winner selection:
  - Winner is the first set req_valid bit searching from ptr upward, wrapping at NUM_REQ.
  - req_ready is combinational: the one-hot winner when grant=1, else all zero.
- On grant:
  - Winner data and index load the register; link_valid=1 next cycle. Latency from accept to link_valid is 1 cycle.
  - ptr becomes winner+1 mod NUM_REQ.
  - The credit is consumed at grant, not at drain.
- Drain with no grant in the same cycle: link_valid=0 next cycle. Drain with grant: back-to-back word, link_valid stays 1.
- link_data and link_src are stable while link_valid && !link_ready.
- Token detection: ret = token_in ^ token_q; token_q <= token_in every cycle.
- Credit update:
  - grant only: credits-1.
  - ret only: credits+1.
  - grant and ret together: credits unchanged.
  - ret while credits==CREDITS and no grant: credits stays CREDITS (saturate) and credit_err<=1 until reset.
- credits==0: no grant, req_ready stays all zero, and a pending link word still drains.
- Requester valid may drop without a handshake; the arbiter re-evaluates every cycle.
- enable deassert: takes effect the same cycle (no grant); the held word still drains.
- Reset mid-operation:
  - A held word is discarded and in-flight credits are restored to CREDITS.
  - The downstream must be reset together with this block.

Decomposition:
- Package link_pkg holds:
  - LINK_DATA_W=64, LINK_CREDITS=8, LINK_CW=4.
  - Typedef link_word_t (64-bit).
  - Typedef credit_t (CW-bit).
- Sub-module rr_arbiter:
  - Parameter N; inputs req[N], ptr, en.
  - Outputs gnt one-hot and gnt_idx.
  - Combinational priority rotation; the pointer register stays in the top level.

Test Plan:
- Reset, then req_valid=4'b0001 with data 0xA5 held, link_ready=1 and no tokens -> 8 words accepted on consecutive cycles, credits counts 8->0, 9th request stalls with req_ready=0, link_valid falls after the 8th drain.
- req_valid=4'b1111, link_ready=1, token toggled every cycle -> grants rotate 0,1,2,3,0..., link_src follows the same order, credits stays 8 (each token return offsets that cycle's grant).
- A word held with link_ready=0 for 5 cycles -> link_data and link_src are unchanged, req_ready=0 throughout, and the next grant comes in the cycle link_ready rises.
- Credits at 8, idle, token_in toggled once -> credits stays 8, credit_err=1 and stays set until rst pulses low.
- Credits=0 with one word held, then token toggled in the same cycle as link_ready=1 -> word drains, credits becomes 1, and the grant occurs the following cycle.
- rst asserted low while link_valid=1 and credits=3 -> link_valid=0 and credits=8 immediately (asynchronous); after release, normal operation resumes with ptr=0.
